m_pkt_match: RTL

Streaming packet classifier that sits directly downstream of the ingress packet interface and upstream of the host egress. It consumes 8-byte `in_t` beats, tracks the word offset of each beat within its packet, and compares each full word against a table of `sym_match_t` entries. It forwards every accepted beat as an `out_t` with one cycle of latency, and reports the resolved `buffer` token on the packet's EOP beat.

---
 rtl/m_pkt_match.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/m_pkt_match.sv
// m_pkt_match: streaming packet classifier.
// Tracks the word offset of each 8-byte beat within its packet, compares
// full words against a small match table (lowest index wins, first hit per
// packet sticks), and forwards beats through one output register stage.
// The resolved buffer token appears only on the EOP beat.

package m_pkg;

    typedef logic [7:0] packet_word_off_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  length;
        logic [63:0] data;
    } in_t;

    typedef struct packed {
        logic             valid;
        packet_word_off_t off;
        logic [63:0]      match;
        logic [7:0]       buffer;
    } sym_match_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  length;
        logic [63:0] data;
        logic [7:0]  buffer;
    } out_t;

endpackage

module m_pkt_match #(
    parameter int N_MATCH = 4
) (
    input  logic                                clk,
    input  logic                                arst_n,
    input  logic                                in_vld,
    input  m_pkg::in_t                          in,
    output logic                                in_rdy,
    input  m_pkg::sym_match_t [N_MATCH-1:0]     cfg_match,
    output logic                                out_vld,
    output m_pkg::out_t                         out,
    input  logic                                out_rdy,
    output logic                                err_framing
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    m_pkg::packet_word_off_t word_q, word_d;
    logic                    ovf_q, ovf_d;
    logic                    hit_q, hit_d;
    logic [7:0]              buf_q, buf_d;
    logic                    err_q, err_d;
    logic                    out_vld_q, out_vld_d;
    m_pkg::out_t             out_q, out_d;

    logic                    accept_s;
    logic                    drop_s;
    logic                    fwd_s;
    m_pkg::packet_word_off_t idx_s;
    logic                    ovf_eff_s;
    logic                    hit_prev_s;
    logic [7:0]              buf_prev_s;
    logic [N_MATCH-1:0]      match_s;
    logic                    any_hit_s;
    logic [7:0]              win_buf_s;

    // A beat may enter whenever the output register is empty or draining this cycle.
    assign in_rdy      = !out_vld_q || out_rdy;
    assign out_vld     = out_vld_q;
    assign out         = out_q;
    assign err_framing = err_q;

    // Per-beat context: SOP overrides the running word index, overflow and hit state.
    always_comb begin
        accept_s   = in_vld && in_rdy;
        idx_s      = in.sop ? 8'd0  : word_q;
        ovf_eff_s  = in.sop ? 1'b0  : ovf_q;
        hit_prev_s = in.sop ? 1'b0  : hit_q;
        buf_prev_s = in.sop ? 8'h00 : buf_q;
        case (state_q)
            ST_IDLE: drop_s = !in.sop;
            ST_PKT:  drop_s = 1'b0;
            default: drop_s = 1'b0;
        endcase
        fwd_s = accept_s && !drop_s;
    end

    // Full-word compare of the current beat against every enabled table entry.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < N_MATCH; i++) begin
            match_s[i] = !ovf_eff_s
                      && cfg_match[i].valid
                      && (cfg_match[i].off == idx_s)
                      && (in.length == 3'd7)
                      && (in.data == cfg_match[i].match);
        end
    end

    // Priority encode: scanning from the top lets the lowest hitting index win.
    always_comb begin
        win_buf_s = 8'h00;
        for (int i = N_MATCH - 1; i >= 0; i--) begin
            win_buf_s = match_s[i] ? cfg_match[i].buffer : win_buf_s;
        end
        any_hit_s = |match_s;
    end

    // Next-state for framing, word tracking, hit latching and the output stage.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        ovf_d     = ovf_q;
        hit_d     = hit_q;
        buf_d     = buf_q;
        err_d     = err_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;

        if (accept_s && drop_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (fwd_s) begin
            state_d = in.eop ? ST_IDLE : ST_PKT;

            // Index 255 is still compared; everything past it is not.
            if (idx_s == 8'hFF) begin
                word_d = 8'hFF;
                ovf_d  = 1'b1;
            end else begin
                word_d = idx_s + 8'd1;
                ovf_d  = ovf_eff_s;
            end

            // Only the first hitting beat of a packet decides the token.
            if (!hit_prev_s && any_hit_s) begin
                hit_d = 1'b1;
                buf_d = win_buf_s;
            end else begin
                hit_d = hit_prev_s;
                buf_d = buf_prev_s;
            end

            out_d.sop    = in.sop;
            out_d.eop    = in.eop;
            out_d.length = in.length;
            out_d.data   = in.data;
            out_d.buffer = in.eop ? buf_d : 8'h00;
            out_vld_d    = 1'b1;
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // State registers; reset discards everything, including a held output beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            word_q    <= 8'd0;
            ovf_q     <= 1'b0;
            hit_q     <= 1'b0;
            buf_q     <= 8'h00;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            ovf_q     <= ovf_d;
            hit_q     <= hit_d;
            buf_q     <= buf_d;
            err_q     <= err_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

endmodule
